// File: rtl/mem_bus_arbiter.sv
// Shares the external memory bus between instruction fetch and the MEM-stage data port.
// One transaction at a time (IDLE -> ADDR -> RESP -> DONE); data wins unless fetch is starving.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_flush,
  output logic [31:0] inst_rdata,
  output logic        inst_valid,
  output logic        inst_stall,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_sel,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_valid,
  output logic        data_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {StIdle, StAddr, StResp, StDone} state_e;
  typedef enum logic {OwnInst, OwnData} owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic            drop_q, drop_d;

  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [3:0]      bus_sel_q, bus_sel_d;
  logic [31:0]     bus_addr_q, bus_addr_d;
  logic [31:0]     bus_wdata_q, bus_wdata_d;

  logic [31:0]     inst_rdata_q, inst_rdata_d;
  logic [31:0]     data_rdata_q, data_rdata_d;
  logic            inst_valid_q, inst_valid_d;
  logic            data_valid_q, data_valid_d;

  logic            starved;
  logic            grant_data;
  logic            grant_inst;
  logic [31:0]     rsp_data;

  // Fetch is starved once the data port has won STARVE_LIMIT times in a row against it.
  always_comb begin
    starved    = starve_cnt_q >= CntW'(STARVE_LIMIT);
    grant_data = data_req & (~inst_req | ~starved);
    grant_inst = ~grant_data & inst_req & ~inst_flush;
    rsp_data   = bus_we_q ? 32'h0 : bus_rdata;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    drop_d       = drop_q;
    bus_req_d    = 1'b0;
    bus_we_d     = bus_we_q;
    bus_sel_d    = bus_sel_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_valid_d = 1'b0;
    data_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        drop_d = 1'b0;
        if (!inst_req) begin
          starve_cnt_d = '0;
        end
        if (grant_data) begin
          state_d     = StAddr;
          owner_d     = OwnData;
          bus_req_d   = 1'b1;
          bus_we_d    = data_we;
          bus_sel_d   = data_sel;
          bus_addr_d  = data_addr;
          bus_wdata_d = data_wdata;
          if (inst_req && !starved) begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
          end
        end else if (grant_inst) begin
          state_d      = StAddr;
          owner_d      = OwnInst;
          bus_req_d    = 1'b1;
          bus_we_d     = 1'b0;
          bus_sel_d    = 4'b1111;
          bus_addr_d   = inst_addr;
          bus_wdata_d  = 32'h0;
          starve_cnt_d = '0;
        end
      end

      StAddr: begin
        if (owner_q == OwnInst && inst_flush) begin
          drop_d = 1'b1;
        end
        if (bus_addr_ok) begin
          state_d = StResp;
        end else begin
          bus_req_d = 1'b1;
        end
      end

      StResp: begin
        if (owner_q == OwnInst && inst_flush) begin
          drop_d = 1'b1;
        end
        // A flush landing in the same cycle as the response must also suppress the pulse.
        if (bus_data_ok) begin
          state_d = StDone;
          if (owner_q == OwnInst) begin
            inst_rdata_d = rsp_data;
            inst_valid_d = ~(drop_q | inst_flush);
          end else begin
            data_rdata_d = rsp_data;
            data_valid_d = 1'b1;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
        drop_d  = 1'b0;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= OwnInst;
      starve_cnt_q <= '0;
      drop_q       <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_sel_q    <= 4'b0000;
      bus_addr_q   <= 32'h0;
      bus_wdata_q  <= 32'h0;
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      drop_q       <= drop_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_sel_q    <= bus_sel_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_valid_q <= inst_valid_d;
      data_valid_q <= data_valid_d;
    end
  end

  always_comb begin
    bus_req    = bus_req_q;
    bus_we     = bus_we_q;
    bus_sel    = bus_sel_q;
    bus_addr   = bus_addr_q;
    bus_wdata  = bus_wdata_q;
    inst_rdata = inst_rdata_q;
    inst_valid = inst_valid_q;
    data_rdata = data_rdata_q;
    data_valid = data_valid_q;
    inst_stall = inst_req & ~inst_valid_q;
    data_stall = data_req & ~data_valid_q;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: requesters and slave driven from a transaction-level model,
// expected responses queued to a monitor that checks every valid pulse and stall flag.
module tb_mem_bus_arbiter;

  localparam int unsigned Limit = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_flush, inst_valid, inst_stall;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_we, data_valid, data_stall;
  logic [3:0]  data_sel;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_we, bus_addr_ok, bus_data_ok;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_flush  (inst_flush),
    .inst_rdata  (inst_rdata),
    .inst_valid  (inst_valid),
    .inst_stall  (inst_stall),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_sel    (data_sel),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_rdata  (data_rdata),
    .data_valid  (data_valid),
    .data_stall  (data_stall),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_sel     (bus_sel),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t iq[$];
  exp_t dq[$];

  // Bus ownership as the model sees it, one entry per cycle.
  typedef enum int {PhFree, PhAddr, PhResp, PhDone} ph_e;
  ph_e         ph = PhFree;
  bit          own_inst, dropped, rel_inst, rel_data, rst_chk;
  logic        g_we;
  logic [3:0]  g_sel;
  logic [31:0] g_addr, g_wdata;
  int          a_wait, d_wait, starve;

  bit          want_inst, want_data, flush_resp, do_reset, fix_rd;
  logic [31:0] w_iaddr, w_daddr, w_wdata, fix_rdata;
  logic        w_we;
  logic [3:0]  w_sel;
  int unsigned inst_pct, data_pct, flush_pct, amax, dmin, dmax;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock of requester + slave behaviour plus the reference arbitration decision.
  task automatic tick();
    logic [31:0] rd;
    exp_t        e;
    @(posedge clk);
    #1;
    chk("bus_req", bus_req, (ph == PhAddr));
    if (ph == PhAddr) begin
      chk("bus_we", bus_we, g_we);
      chk("bus_sel", bus_sel, g_sel);
      chk("bus_addr", bus_addr, g_addr);
      chk("bus_wdata", bus_wdata, g_wdata);
    end
    if (rst_chk) begin
      rst_chk = 0;
      chk("rst_bus_we", bus_we, 0);
      chk("rst_bus_sel", bus_sel, 0);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_bus_wdata", bus_wdata, 0);
      chk("rst_inst_rdata", inst_rdata, 0);
      chk("rst_data_rdata", data_rdata, 0);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_data_valid", data_valid, 0);
    end

    rst         = 1'b0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    inst_flush  = 1'b0;
    bus_rdata   = $urandom();
    if (rel_inst) inst_req = 1'b0;
    if (rel_data) data_req = 1'b0;
    rel_inst = 0;
    rel_data = 0;

    if (!inst_req) begin
      if (want_inst) begin
        inst_req  = 1'b1;
        inst_addr = w_iaddr;
        want_inst = 0;
      end else if ($urandom_range(99) < inst_pct) begin
        inst_req  = 1'b1;
        inst_addr = $urandom() & 32'hFFFF_FFFC;
      end
    end
    if (!data_req) begin
      if (want_data) begin
        data_req   = 1'b1;
        data_we    = w_we;
        data_sel   = w_sel;
        data_addr  = w_daddr;
        data_wdata = w_wdata;
        want_data  = 0;
      end else if ($urandom_range(99) < data_pct) begin
        data_req   = 1'b1;
        data_we    = 1'($urandom_range(1));
        data_sel   = 4'($urandom_range(15));
        data_addr  = $urandom();
        data_wdata = $urandom();
      end
    end

    case (ph)
      PhAddr: begin
        if (do_reset) begin
          do_reset = 0;
          rst      = 1'b1;
          inst_req = 1'b0;
          data_req = 1'b0;
          rst_chk  = 1;
          starve   = 0;
          ph       = PhFree;
        end else begin
          if ($urandom_range(99) < flush_pct) begin
            inst_flush = 1'b1;
            if (own_inst) dropped = 1;
          end
          if (a_wait == 0) begin
            bus_addr_ok = 1'b1;
            d_wait      = int'($urandom_range(dmax, dmin));
            ph          = PhResp;
          end else begin
            a_wait--;
          end
        end
      end
      PhResp: begin
        if (($urandom_range(99) < flush_pct) || (flush_resp && own_inst)) begin
          inst_flush = 1'b1;
          if (own_inst) begin
            dropped    = 1;
            flush_resp = 0;
          end
        end
        if (d_wait == 0) begin
          rd          = fix_rd ? fix_rdata : $urandom();
          bus_data_ok = 1'b1;
          bus_rdata   = rd;
          e.rdata     = g_we ? 32'h0 : rd;
          e.cyc       = cyc + 1;
          if (!own_inst) dq.push_back(e);
          else if (!dropped) iq.push_back(e);
          ph = PhDone;
        end else begin
          d_wait--;
        end
      end
      PhDone: begin
        if (own_inst) rel_inst = !dropped;
        else rel_data = 1;
        ph = PhFree;
      end
      default: begin
        if ($urandom_range(99) < flush_pct) inst_flush = 1'b1;
        if (!inst_req) starve = 0;
        if (data_req && (!inst_req || starve < int'(Limit))) begin
          own_inst = 0;
          g_we     = data_we;
          g_sel    = data_sel;
          g_addr   = data_addr;
          g_wdata  = data_wdata;
          if (inst_req) starve++;
          ph = PhAddr;
        end else if (inst_req && !inst_flush) begin
          own_inst = 1;
          g_we     = 1'b0;
          g_sel    = 4'b1111;
          g_addr   = inst_addr;
          g_wdata  = 32'h0;
          starve   = 0;
          ph       = PhAddr;
        end
        if (ph == PhAddr) begin
          dropped = 0;
          a_wait  = int'($urandom_range(amax, 0));
        end
      end
    endcase
  endtask

  function automatic bit busy();
    return (ph != PhFree) || inst_req || data_req || want_inst || want_data;
  endfunction

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic settle();
    int n = 0;
    tick();
    n++;
    while (busy() && n < 300) begin
      tick();
      n++;
    end
    chk("settle_timeout", busy(), 0);
  endtask

  // Monitor: pops an expected response on every valid pulse, flags missing or stray ones.
  always @(posedge clk) begin
    exp_t e;
    bit   exp_iv, exp_dv;
    #2;
    exp_iv = (iq.size() > 0) && (iq[0].cyc == cyc);
    exp_dv = (dq.size() > 0) && (dq[0].cyc == cyc);
    if (inst_valid === 1'b1) begin
      if (iq.size() == 0) begin
        chk("inst_valid_unexpected", inst_valid, 0);
      end else begin
        e = iq.pop_front();
        chk("inst_valid_cycle", cyc, e.cyc);
        chk("inst_rdata", inst_rdata, e.rdata);
      end
    end else if (iq.size() > 0 && iq[0].cyc <= cyc) begin
      chk("inst_valid_missing", inst_valid, 1);
      void'(iq.pop_front());
    end
    if (data_valid === 1'b1) begin
      if (dq.size() == 0) begin
        chk("data_valid_unexpected", data_valid, 0);
      end else begin
        e = dq.pop_front();
        chk("data_valid_cycle", cyc, e.cyc);
        chk("data_rdata", data_rdata, e.rdata);
      end
    end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
      chk("data_valid_missing", data_valid, 1);
      void'(dq.pop_front());
    end
    chk("inst_stall", inst_stall, inst_req & ~exp_iv);
    chk("data_stall", data_stall, data_req & ~exp_dv);
  end

  initial begin
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = 32'h0; inst_flush = 1'b0;
    data_req = 1'b0; data_we = 1'b0; data_sel = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    inst_pct = 0; data_pct = 0; flush_pct = 0;
    amax = 0; dmin = 0; dmax = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rst_chk = 1;

    // Lone fetch against a zero-wait slave.
    fix_rd = 1; fix_rdata = 32'h02800C21;
    w_iaddr = 32'h1C00_0000; want_inst = 1;
    settle();
    fix_rd = 0;

    // Simultaneous fetch and load: load goes first.
    w_iaddr = 32'h1C00_0040; want_inst = 1;
    w_daddr = 32'h0000_1004; w_we = 1'b0; w_sel = 4'b1111; w_wdata = 32'h0; want_data = 1;
    settle();

    // Half-word store returns zero data.
    w_daddr = 32'h0000_2000; w_we = 1'b1; w_sel = 4'b0011; w_wdata = 32'hBEEF_1234; want_data = 1;
    settle();

    // Flush during the response phase, with a one-cycle slave wait.
    dmin = 1; dmax = 1;
    w_iaddr = 32'h1C00_0080; want_inst = 1; flush_resp = 1;
    settle();
    dmin = 0; dmax = 0;

    // Reset while the address phase is on the bus, then a fresh fetch.
    w_iaddr = 32'h1C00_00C0; want_inst = 1; do_reset = 1;
    settle();
    w_iaddr = 32'h1C00_0100; want_inst = 1;
    settle();

    // Both ports saturated: fetch must win every Limit+1 grants.
    inst_pct = 100; data_pct = 100;
    run(120);

    // Random traffic with slave wait states and flushes.
    amax = 2; dmin = 0; dmax = 3;
    inst_pct = 30; data_pct = 40; flush_pct = 8;
    run(2500);

    inst_pct = 0; data_pct = 0; flush_pct = 0;
    settle();
    run(3);
    chk("queues_drained", iq.size() + dq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
